// File: rtl/hub75_line_prefetcher_if.sv
// Control, frame-memory and driver read-port signals of the HUB-75 line prefetcher.
// The slave modport is the prefetcher; the master modport is its environment.
interface hub75_line_prefetcher_if #(
    parameter int k_width      = 64,
    parameter int k_rows       = 32,
    parameter int k_color_bits = 8
);
    localparam int kXw = $clog2(k_width);
    localparam int kRw = $clog2(k_rows);
    localparam int kPw = $clog2(k_color_bits);
    localparam int kAw = 1 + kRw + kXw;

    logic                      fill_start;
    logic [kRw-1:0]            fill_row;
    logic [kPw-1:0]            fill_plane;
    logic                      busy;
    logic                      done;
    logic                      swap;
    logic                      front_bank;
    logic [kAw-1:0]            mem_address;
    logic [3*k_color_bits-1:0] mem_read_data;
    logic [kXw-1:0]            read_x;
    logic [5:0]                read_rgb;

    modport slave (
        input  fill_start, fill_row, fill_plane, swap, mem_read_data, read_x,
        output busy, done, front_bank, mem_address, read_rgb
    );

    modport master (
        output fill_start, fill_row, fill_plane, swap, mem_read_data, read_x,
        input  busy, done, front_bank, mem_address, read_rgb
    );
endinterface

// File: rtl/hub75_line_prefetcher.sv
// Fetches one scan row's top/bottom pixel pairs, extracts a bit-plane and
// writes packed 6-bit column words into the back bank of a double-buffered line store.
module hub75_line_prefetcher #(
    parameter int k_width      = 64,
    parameter int k_rows       = 32,
    parameter int k_color_bits = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    hub75_line_prefetcher_if.slave bus
);
    localparam int kXw = $clog2(k_width);
    localparam int kRw = $clog2(k_rows);
    localparam int kPw = $clog2(k_color_bits);
    localparam int kAw = 1 + kRw + kXw;
    localparam logic [kXw-1:0] kLastX = kXw'(k_width - 1);

    typedef enum logic [2:0] {
        kIdle,
        kTop,
        kBottom,
        kFlush,
        kDone
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [kXw-1:0]          r_x;
    logic [kRw-1:0]          r_row;
    logic [kPw-1:0]          r_plane;
    logic                    r_front;
    logic                    r_back;
    logic [kAw-1:0]          r_addr;
    logic [2:0]              r_top;
    logic [5:0]              r_rgb;
    logic [5:0]              r_store [0:2*k_width-1];

    logic                    w_busy;
    logic                    w_done;
    logic                    w_we;
    logic [kXw-1:0]          w_wr_x;
    logic                    w_last;
    logic                    w_start;
    logic                    w_swap_ok;
    logic [k_color_bits-1:0] w_r;
    logic [k_color_bits-1:0] w_g;
    logic [k_color_bits-1:0] w_b;
    logic [2:0]              w_bits;

    assign w_r    = bus.mem_read_data[3*k_color_bits-1:2*k_color_bits];
    assign w_g    = bus.mem_read_data[2*k_color_bits-1:k_color_bits];
    assign w_b    = bus.mem_read_data[k_color_bits-1:0];
    assign w_bits = {w_b[r_plane], w_g[r_plane], w_r[r_plane]};
    assign w_last = (r_x == kLastX);

    always_ff @(posedge clock) begin
        if (reset) r_state <= kIdle;
        else       r_state <= w_next;
    end

    // Bottom-half data for column x-1 lands while column x's top address is out.
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        w_we   = 1'b0;
        w_wr_x = r_x;
        unique case (r_state)
            kIdle: begin
                if (bus.fill_start) w_next = kTop;
            end
            kTop: begin
                w_busy = 1'b1;
                w_we   = (r_x != '0);
                w_wr_x = r_x - kXw'(1);
                w_next = kBottom;
            end
            kBottom: begin
                w_busy = 1'b1;
                w_next = w_last ? kFlush : kTop;
            end
            kFlush: begin
                w_busy = 1'b1;
                w_we   = 1'b1;
                w_next = kDone;
            end
            kDone: begin
                w_done = 1'b1;
                w_next = kIdle;
            end
            default: w_next = kIdle;
        endcase
    end

    assign w_start   = (r_state == kIdle) && bus.fill_start;
    assign w_swap_ok = bus.swap && !w_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_x     <= '0;
            r_row   <= '0;
            r_plane <= '0;
            r_front <= 1'b0;
            r_back  <= 1'b0;
            r_addr  <= '0;
            r_top   <= '0;
            r_rgb   <= '0;
        end else begin
            if (w_swap_ok) r_front <= ~r_front;
            // A same-cycle swap moves the front, so the fill targets the old front.
            if (w_start) begin
                r_row   <= bus.fill_row;
                r_plane <= bus.fill_plane;
                r_back  <= bus.swap ? r_front : ~r_front;
                r_x     <= '0;
                r_addr  <= {1'b0, bus.fill_row, kXw'(0)};
            end
            if (r_state == kTop) r_addr <= {1'b1, r_row, r_x};
            if (r_state == kBottom) begin
                r_top <= w_bits;
                if (!w_last) begin
                    r_x    <= r_x + kXw'(1);
                    r_addr <= {1'b0, r_row, r_x + kXw'(1)};
                end
            end
            r_rgb <= r_store[{r_front, bus.read_x}];
        end
    end

    always_ff @(posedge clock) begin
        if (w_we) r_store[{r_back, w_wr_x}] <= {w_bits, r_top};
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.front_bank  = r_front;
    assign bus.mem_address = r_addr;
    assign bus.read_rgb    = r_rgb;
endmodule

// File: tb/tb_hub75_line_prefetcher.sv
// Scoreboard bench for hub75_line_prefetcher: a queue-based reference model
// of the frame memory and line store, checked by a separate monitor process.
module tb_hub75_line_prefetcher;
    localparam int W = 64;
    localparam int R = 32;
    localparam int C = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    hub75_line_prefetcher_if #(.k_width(W), .k_rows(R), .k_color_bits(C)) bus();

    hub75_line_prefetcher #(.k_width(W), .k_rows(R), .k_color_bits(C)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    logic [23:0] mem  [0:2*R*W-1];
    logic [5:0]  bank [0:1][0:W-1];
    logic [5:0]  pend [0:W-1];
    int          front  = 0;
    int          target = 0;
    int          addr_q[$];
    int          done_q[$];
    int          rd_q[$];
    logic        rd_req = 1'b0;
    logic        rd_d   = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Frame memory with one-cycle synchronous read latency.
    always @(posedge clk) begin
        cyc                <= cyc + 1;
        bus.mem_read_data  <= mem[bus.mem_address];
        rd_d               <= rd_req;
    end

    always @(negedge clk) begin
        if (rd_d) check("read_rgb", int'(bus.read_rgb),
                        rd_q.size() > 0 ? rd_q.pop_front() : -1);
        if (bus.busy && addr_q.size() > 0)
            check("mem_address", int'(bus.mem_address), addr_q.pop_front());
        if (bus.done) begin
            if (done_q.size() == 0) check("spurious_done", int'(bus.done), 0);
            else                    check("done_cycle", cyc, done_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic bitof(input logic [23:0] v, input int sh);
        return v[sh];
    endfunction

    // Word = {b2,g2,r2,b1,g1,r1}; channel c (0=r,1=g,2=b) sits at bit 8*(2-c)+plane.
    function automatic logic [5:0] word(input int row, input int plane, input int x);
        logic [23:0] t;
        logic [23:0] b;
        t = mem[row*W + x];
        b = mem[R*W + row*W + x];
        return {bitof(b, plane), bitof(b, 8 + plane), bitof(b, 16 + plane),
                bitof(t, plane), bitof(t, 8 + plane), bitof(t, 16 + plane)};
    endfunction

    task automatic randomize_mem();
        for (int i = 0; i < 2*R*W; i++) mem[i] = 24'($urandom);
    endtask

    task automatic do_fill(input int row, input int plane, input bit with_swap);
        bus.fill_start = 1'b1;
        bus.fill_row   = 5'(row);
        bus.fill_plane = 3'(plane);
        bus.swap       = with_swap;
        if (with_swap) front ^= 1;
        target = 1 - front;
        for (int x = 0; x < W; x++) begin
            pend[x] = word(row, plane, x);
            addr_q.push_back(row*W + x);
            addr_q.push_back(R*W + row*W + x);
        end
        done_q.push_back(cyc + 2*W + 2);
        tick();
        bus.fill_start = 1'b0;
        bus.swap       = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2*W + 20; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("done_seen", int'(seen), 1);
        if (!seen) done_q.delete();
        else for (int x = 0; x < W; x++) bank[target][x] = pend[x];
        tick();
    endtask

    task automatic do_swap();
        bus.swap = 1'b1;
        front ^= 1;
        tick();
        bus.swap = 1'b0;
        check("front_after_swap", int'(bus.front_bank), front);
    endtask

    task automatic read_all(input bit shuffled);
        int x;
        for (int i = 0; i < W; i++) begin
            x = shuffled ? int'($urandom_range(W - 1)) : i;
            bus.read_x = 6'(x);
            rd_req     = 1'b1;
            rd_q.push_back(int'(bank[front][x]));
            tick();
        end
        rd_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        bus.fill_start = 1'b0;
        bus.fill_row   = '0;
        bus.fill_plane = '0;
        bus.swap       = 1'b0;
        bus.read_x     = '0;
        randomize_mem();

        for (int i = 0; i < 3; i++) begin
            bus.fill_start = 1'($urandom);
            bus.fill_row   = 5'($urandom);
            bus.fill_plane = 3'($urandom);
            bus.swap       = 1'($urandom);
            bus.read_x     = 6'($urandom);
            tick();
        end
        check("rst_busy",     int'(bus.busy),        0);
        check("rst_done",     int'(bus.done),        0);
        check("rst_front",    int'(bus.front_bank),  0);
        check("rst_read_rgb", int'(bus.read_rgb),    0);
        check("rst_mem_addr", int'(bus.mem_address), 0);
        bus.fill_start = 1'b0;
        bus.swap       = 1'b0;
        rst            = 1'b0;
        repeat (4) tick();

        // Row 5, plane 7 pattern; ignored mid-fill start and swap.
        for (int x = 0; x < W; x++) begin
            mem[5*W + x]       = {8'h80, 8'h00, (x % 2 == 1) ? 8'hFF : 8'h00};
            mem[R*W + 5*W + x] = {8'h00, 8'h80, 8'h00};
        end
        do_fill(5, 7, 1'b0);
        check("busy_in_fill", int'(bus.busy), 1);
        repeat (20) tick();
        bus.fill_start = 1'b1;
        bus.fill_row   = 5'd9;
        bus.fill_plane = 3'd3;
        tick();
        bus.fill_start = 1'b0;
        bus.swap       = 1'b1;
        tick();
        bus.swap = 1'b0;
        check("front_swap_busy", int'(bus.front_bank), front);
        wait_done();
        check("busy_after_done", int'(bus.busy), 0);
        do_swap();
        read_all(1'b0);

        // Random fill into bank 0, then present it.
        randomize_mem();
        do_fill(int'($urandom_range(R - 1)), int'($urandom_range(C - 1)), 1'b0);
        wait_done();
        do_swap();
        read_all(1'b1);

        // Swap and fill together; bank 1 stays readable during the fill.
        randomize_mem();
        do_fill(int'($urandom_range(R - 1)), int'($urandom_range(C - 1)), 1'b1);
        check("front_sim_swap", int'(bus.front_bank), 1);
        read_all(1'b0);
        wait_done();
        check("front_kept", int'(bus.front_bank), 1);
        do_swap();
        read_all(1'b1);

        // Reset 40 cycles into a fill, then a clean fill.
        randomize_mem();
        do_fill(int'($urandom_range(R - 1)), int'($urandom_range(C - 1)), 1'b0);
        repeat (39) tick();
        rst = 1'b1;
        tick();
        addr_q.delete();
        done_q.delete();
        front = 0;
        check("midrst_busy",  int'(bus.busy),        0);
        check("midrst_done",  int'(bus.done),        0);
        check("midrst_front", int'(bus.front_bank),  0);
        check("midrst_addr",  int'(bus.mem_address), 0);
        check("midrst_rgb",   int'(bus.read_rgb),    0);
        rst = 1'b0;
        repeat (150) tick();
        do_fill(int'($urandom_range(R - 1)), int'($urandom_range(C - 1)), 1'b0);
        wait_done();
        do_swap();
        read_all(1'b1);
        read_all(1'b0);

        check("addr_q_drained", addr_q.size(), 0);
        check("rd_q_drained",   rd_q.size(),   0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
